// File: rtl/channel_sum_reducer_if.sv
// FIFO-style channel bundle: master is the reducer side, slave is the FIFO side.
interface channel_sum_reducer_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] out_data;
  logic [WIDTH-1:0] in_data;
  logic             read_ready;
  logic             write_ready;
  logic             read_valid;
  logic             write_valid;
  logic             rst;

  modport master (
    input  out_data, read_ready, write_ready,
    output in_data, read_valid, write_valid, rst
  );

  modport slave (
    output out_data, read_ready, write_ready,
    input  in_data, read_valid, write_valid, rst
  );
endinterface

// File: rtl/channel_sum_reducer.sv
// Single-shot reducer: reads COUNT words from in_ch, sums them modulo 2^WIDTH,
// writes the sum once to out_ch, then holds valid until reset.
module channel_sum_reducer #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned COUNT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  channel_sum_reducer_if.master  in_ch,
  channel_sum_reducer_if.master  out_ch,
  output logic                   valid
);
  localparam int unsigned CW = $clog2(COUNT + 1);

  typedef enum logic [3:0] {
    INIT, LOOP, WAIT_IN, READ, ACC, CHK, WAIT_OUT, WRITE, DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic             rd_pulse;
  logic             wr_pulse;
  logic             done_q;

  // Strobes are registered on the transition into READ/WRITE/DONE, so each
  // is high exactly while the FSM sits in that state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      acc      <= '0;
      cnt      <= '0;
      rd_pulse <= 1'b0;
      wr_pulse <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      rd_pulse <= 1'b0;
      wr_pulse <= 1'b0;
      case (state)
        INIT: begin
          acc   <= '0;
          state <= LOOP;
        end
        LOOP: begin
          cnt   <= '0;
          state <= WAIT_IN;
        end
        WAIT_IN: begin
          if (in_ch.read_ready) begin
            cnt      <= cnt + CW'(1);
            rd_pulse <= 1'b1;
            state    <= READ;
          end
        end
        READ:    state <= ACC;
        ACC: begin
          // The channel presents the requested word the cycle after the pulse.
          acc   <= acc + in_ch.out_data;
          state <= CHK;
        end
        CHK:     state <= (cnt == CW'(COUNT)) ? WAIT_OUT : WAIT_IN;
        WAIT_OUT: begin
          if (out_ch.write_ready) begin
            wr_pulse <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          done_q <= 1'b1;
          state  <= DONE;
        end
        DONE:    state <= DONE;
        default: state <= INIT;
      endcase
    end
  end

  assign in_ch.read_valid   = rd_pulse;
  assign in_ch.write_valid  = 1'b0;
  assign in_ch.in_data      = '0;
  assign in_ch.rst          = 1'b0;

  assign out_ch.write_valid = wr_pulse;
  assign out_ch.read_valid  = 1'b0;
  assign out_ch.in_data     = acc;
  assign out_ch.rst         = 1'b0;

  assign valid = done_q;

  logic unused_inputs;
  assign unused_inputs = ^{in_ch.write_ready, out_ch.out_data, out_ch.read_ready};
endmodule

// File: tb/tb_channel_sum_reducer.sv
// Bench for channel_sum_reducer: FIFO model on the input channel, expected sums
// queued when words are loaded and popped once the write pulse has been seen.
module tb_channel_sum_reducer;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned COUNT = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  channel_sum_reducer_if #(.WIDTH(WIDTH)) in_ch ();
  channel_sum_reducer_if #(.WIDTH(WIDTH)) out_ch ();
  logic valid;

  channel_sum_reducer #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk    (clk),
    .rst    (rst),
    .in_ch  (in_ch),
    .out_ch (out_ch),
    .valid  (valid)
  );

  logic [WIDTH-1:0] words [8];
  int               nwords = 4;
  int               rd_idx;
  logic             in_en  = 1'b1;
  logic             out_en = 1'b1;

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [WIDTH-1:0] sb [$];

  int               cyc;
  int               rd_pulses, wr_pulses, wr_cycle, valid_cycle;
  logic [WIDTH-1:0] wr_data;

  assign in_ch.read_ready   = in_en && (rd_idx < nwords);
  assign in_ch.write_ready  = 1'b0;
  assign out_ch.write_ready = out_en;
  assign out_ch.out_data    = '0;
  assign out_ch.read_ready  = 1'b0;

  // Input FIFO model: a read pulse pops a word, visible the following cycle.
  always @(posedge clk) begin
    if (rst) begin
      rd_idx        <= 0;
      in_ch.out_data <= '0;
      cyc           <= 0;
    end else begin
      cyc <= cyc + 1;
      if (in_ch.read_valid && rd_idx < 8) begin
        in_ch.out_data <= words[rd_idx];
        rd_idx         <= rd_idx + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      rd_pulses   <= 0;
      wr_pulses   <= 0;
      wr_cycle    <= -1;
      valid_cycle <= -1;
      wr_data     <= '0;
    end else begin
      if (in_ch.read_valid) rd_pulses <= rd_pulses + 1;
      if (out_ch.write_valid) begin
        wr_pulses <= wr_pulses + 1;
        wr_cycle  <= cyc;
        wr_data   <= out_ch.in_data;
      end
      if (valid === 1'b1 && valid_cycle < 0) valid_cycle <= cyc;
    end
  end

  task automatic load(input logic [WIDTH-1:0] w0, w1, w2, w3);
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    nwords = 4;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_ch.read_valid, out_ch.write_valid, valid} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_strobes: got %b want 000", {in_ch.read_valid, out_ch.write_valid, valid});
    end
    n_cmp++;
    if (out_ch.in_data !== '0) begin
      n_bad++;
      $display("FAIL reset_acc: got %0h want 0", out_ch.in_data);
    end
    n_cmp++;
    if ({in_ch.in_data, in_ch.write_valid, in_ch.rst, out_ch.read_valid, out_ch.rst} !== '0) begin
      n_bad++;
      $display("FAIL tie_offs: got %0h want 0",
               {in_ch.in_data, in_ch.write_valid, in_ch.rst, out_ch.read_valid, out_ch.rst});
    end
  endtask

  task automatic check_run(input string name, input int exp_wr_cycle);
    logic [WIDTH-1:0] exp;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL %s_sb: got empty scoreboard want 1 entry", name);
    end else begin
      exp = sb.pop_front();
      if (wr_data !== exp) begin
        n_bad++;
        $display("FAIL %s_sum: got %0h want %0h", name, wr_data, exp);
      end
    end
    n_cmp++;
    if (rd_pulses !== 4 || wr_pulses !== 1) begin
      n_bad++;
      $display("FAIL %s_pulses: got rd=%0d wr=%0d want rd=4 wr=1", name, rd_pulses, wr_pulses);
    end
    n_cmp++;
    if (wr_cycle !== exp_wr_cycle || valid_cycle !== exp_wr_cycle + 1) begin
      n_bad++;
      $display("FAIL %s_latency: got wr=%0d valid=%0d want wr=%0d valid=%0d",
               name, wr_cycle, valid_cycle, exp_wr_cycle, exp_wr_cycle + 1);
    end
  endtask

  task automatic test_basic();
    bit ok;
    in_en = 1'b1; out_en = 1'b1;
    load(1, 2, 3, 4);
    sb.push_back(32'd10);
    apply_reset();
    wait_valid(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL basic_timeout: got valid=0 want 1"); end
    check_run("basic", 19);
    repeat (5) @(negedge clk);
    n_cmp++;
    if (valid !== 1'b1 || out_ch.in_data !== 32'd10) begin
      n_bad++;
      $display("FAIL basic_hold: got valid=%b data=%0d want valid=1 data=10", valid, out_ch.in_data);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    load(32'hFFFF_FFFF, 1, 5, 0);
    sb.push_back(32'd5);
    apply_reset();
    wait_valid(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL wrap_timeout: got valid=0 want 1"); end
    check_run("wrap", 19);
  endtask

  task automatic test_in_stall();
    bit ok;
    load(10, 20, 30, 40);
    sb.push_back(32'd100);
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rd_idx == 1) break;
    end
    in_en = 1'b0;
    repeat (12) @(negedge clk);
    n_cmp++;
    if (rd_pulses !== 1) begin
      n_bad++;
      $display("FAIL in_stall_pulses: got %0d want 1", rd_pulses);
    end
    in_en = 1'b1;
    wait_valid(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL in_stall_timeout: got valid=0 want 1"); end
    check_run("in_stall", 29);
  endtask

  task automatic test_out_stall();
    bit ok;
    load(5, 6, 7, 8);
    sb.push_back(32'd26);
    out_en = 1'b0;
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cyc == 40) break;
    end
    n_cmp++;
    if (wr_pulses !== 0 || valid !== 1'b0) begin
      n_bad++;
      $display("FAIL out_stall_hold: got wr=%0d valid=%b want wr=0 valid=0", wr_pulses, valid);
    end
    out_en = 1'b1;
    wait_valid(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL out_stall_timeout: got valid=0 want 1"); end
    check_run("out_stall", 41);
  endtask

  task automatic test_mid_reset();
    bit ok;
    load(100, 200, 300, 400);
    apply_reset();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rd_idx == 2) break;
    end
    repeat (2) @(negedge clk);
    load(7, 7, 7, 7);
    sb.push_back(32'd28);
    apply_reset();
    wait_valid(ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL mid_reset_timeout: got valid=0 want 1"); end
    check_run("mid_reset", 19);
  endtask

  task automatic test_done_idle();
    words[4] = 9; words[5] = 9; words[6] = 9; words[7] = 9;
    nwords = 8;
    for (int i = 0; i < 20; i++) begin
      in_en  = i[0];
      out_en = ~i[0];
      @(negedge clk);
      n_cmp++;
      if (in_ch.read_valid !== 1'b0 || out_ch.write_valid !== 1'b0 ||
          valid !== 1'b1 || out_ch.in_data !== 32'd28) begin
        n_bad++;
        $display("FAIL done_idle: got rd=%b wr=%b valid=%b data=%0d want rd=0 wr=0 valid=1 data=28",
                 in_ch.read_valid, out_ch.write_valid, valid, out_ch.in_data);
      end
    end
    n_cmp++;
    if (rd_pulses !== 4 || wr_pulses !== 1) begin
      n_bad++;
      $display("FAIL done_idle_pulses: got rd=%0d wr=%0d want rd=4 wr=1", rd_pulses, wr_pulses);
    end
  endtask

  initial begin
    load(0, 0, 0, 0);
    words[4] = 0; words[5] = 0; words[6] = 0; words[7] = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_in_stall();
    test_out_stall();
    test_mid_reset();
    test_done_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
